peak_frame_ctrl: RTL and testbench
==================================

PEAK_FRAME_CTRL -- requirements
Module: peak_frame_ctrl

Interface
REQ-001 Parameter: DATA_W, default 16, sample width in bits (signed two's complement).
REQ-002 Parameter: FRAME_LEN, default 256, samples per frame; power of two, 2..4096.
REQ-003 Port: clk  in  1  single clock; all logic on rising edge.
REQ-004 Port: rst  in  1  reset; asynchronous, active-high.
REQ-005 Port: start  in  1  arm one frame capture from IDLE.
REQ-006 Port: cont  in  1  continuous mode; sampled at each report handshake.
REQ-007 Port: abort  in  1  discard current frame and return to IDLE.
REQ-008 Port: x  in  DATA_W  input sample.
REQ-009 Port: v  in  1  sample valid.
REQ-010 Port: in_ready  out  1  sample accepted when v and in_ready are both high.
REQ-011 Port: peak  out  DATA_W  frame peak magnitude, unsigned.
REQ-012 Port: peak_idx  out  log2(FRAME_LEN)  index of the peak sample within the frame.
REQ-013 Port: pk_valid  out  1  frame result valid.
REQ-014 Port: pk_ready  in  1  consumer accepts the result.
REQ-015 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, ACCUM, REPORT.
- IDLE->ACCUM on start.
- ACCUM->REPORT on acceptance of sample index FRAME_LEN-1.
- REPORT->ACCUM on pk_valid&pk_ready with cont=1 and abort=0.
- REPORT->IDLE on pk_valid&pk_ready with cont=0 or abort=1.
- ACCUM->IDLE on abort.
REQ-017 in_ready is 1 only in ACCUM; v while in_ready=0 is ignored, and the sample is dropped.
REQ-018 Magnitude |x|; the most negative input saturates to 2^(DATA_W-1)-1.
REQ-019 Running peak updates only when the magnitude is strictly greater than the held peak, so the earliest sample wins a tie; peak_idx is updated with it.
REQ-020 On entry to ACCUM: running peak=0, peak_idx=0, frame counter=0.
REQ-021 The frame counter increments per accepted sample and wraps to 0 after FRAME_LEN-1.
REQ-022 pk_valid rises exactly 1 cycle after the last sample is accepted; the result includes that sample.
REQ-023 peak, peak_idx and pk_valid hold stable in REPORT until the handshake; pk_valid drops the cycle after the handshake.
REQ-024 When REPORT->ACCUM occurs, in_ready is 1 the cycle after the handshake; gap between frames is 1 cycle.
REQ-025 start is ignored outside IDLE; abort is ignored in IDLE.
REQ-026 An abort in ACCUM never produces pk_valid, and partial results are discarded.
REQ-027 An all-zero frame reports peak=0, peak_idx=0.

Reset
REQ-028 Reset state: IDLE, in_ready=0, pk_valid=0, busy=0, peak=0, peak_idx=0, counter=0.
REQ-029 Reset mid-frame or mid-REPORT discards all state immediately; no pk_valid follows.

Configuration
REQ-030 Macro PEAK_NORM_SHIFT_EN, when defined, adds port norm_shift (out, 5 bits): count of leading zeros of the reported peak below the sign position, i.e. the left shift that normalises the frame to full scale.
- Valid with pk_valid and held with peak.
- Equals DATA_W-1 for peak=0.
- Resets to 0.
REQ-031 Without PEAK_NORM_SHIFT_EN the port and its logic are absent; all other behaviour is identical.

Structure
REQ-032 Shared package peak_pkg holds the FSM state enum, the DATA_W default, FRAME_LEN default and the saturating magnitude function.
REQ-033 One sub-module, norm_shift_calc (combinational leading-zero count), is instantiated only under PEAK_NORM_SHIFT_EN.

Verification
REQ-034 FRAME_LEN=8, start, samples 1,-5,3,5,0,2,-1,4 with v=1, pk_ready=1 -> pk_valid 1 cycle after the 8th sample, peak=5, peak_idx=1.
REQ-035 Frame containing -32768 -> peak=32767; with PEAK_NORM_SHIFT_EN, norm_shift=0. All-zero frame -> peak=0, norm_shift=15.
REQ-036 cont=1, pk_ready held 0 for 5 cycles -> outputs stable, in_ready=0, v pulses dropped; after the handshake, in_ready=1 the next cycle and the next frame starts with peak cleared.
REQ-037 abort after 3 samples -> IDLE next cycle, no pk_valid; a following start and a full frame report only the new samples.
REQ-038 Assert rst asynchronously mid-frame and mid-REPORT -> all outputs 0 immediately, state IDLE, no spurious pk_valid after release.
REQ-039 In REPORT, pk_ready=1 and abort=1 in the same cycle with cont=1 -> handshake completes, next state IDLE, busy=0.

Source files
------------

// File: rtl/peak_pkg.sv
// ============================================================================
// Module  : peak_pkg
// Brief   : Shared types, defaults and helpers for the peak frame controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package peak_pkg;

  // Default sample width (signed two's complement)
  localparam int c_DATA_W_DEFAULT    = 16;
  // Default number of samples per frame (power of two, 2..4096)
  localparam int c_FRAME_LEN_DEFAULT = 256;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_REPORT = 2'd2
  } peak_state_t;

  // Saturating magnitude of a w-bit signed value that has been sign-extended
  // to 64 bits. The most negative w-bit code maps to the largest positive
  // code so the result always fits in w bits as an unsigned value.
  function automatic logic [63:0] sat_mag(input logic signed [63:0] xs,
                                          input int w);
    logic signed [63:0] lim;
    lim = 64'sd1 <<< (w - 1);
    if (xs == -lim) begin
      sat_mag = lim - 64'sd1;
    end else if (xs < 64'sd0) begin
      sat_mag = -xs;
    end else begin
      sat_mag = xs;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/norm_shift_calc.sv
// ============================================================================
// Module  : norm_shift_calc
// Brief   : Combinational leading-zero count of an unsigned peak magnitude,
//           measured below the sign position. Gives the left shift that
//           brings the peak to full scale; DATA_W-1 for a zero input.
//           Only compiled when PEAK_NORM_SHIFT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef PEAK_NORM_SHIFT_EN
module norm_shift_calc
  import peak_pkg::*;
#(
  parameter int DATA_W = c_DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0] i_val,
  output logic [4:0]        o_shift
);

  // Highest set bit below the sign position decides the shift; a set sign
  // bit cannot occur for a saturated magnitude but is treated as full scale.
  always_comb begin
    o_shift = 5'(DATA_W - 1);
    for (int i = 0; i < DATA_W - 1; i++) begin
      if (i_val[i]) begin
        o_shift = 5'(DATA_W - 2 - i);
      end
    end
    if (i_val[DATA_W-1]) begin
      o_shift = '0;
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/peak_frame_ctrl.sv
// ============================================================================
// Module  : peak_frame_ctrl
// Brief   : Captures frames of FRAME_LEN signed samples, tracks the earliest
//           largest saturated magnitude and its index, and reports it with a
//           valid/ready handshake. Supports single-shot and continuous mode
//           and abort. Optional macro PEAK_NORM_SHIFT_EN adds norm_shift.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module peak_frame_ctrl
  import peak_pkg::*;
#(
  parameter int DATA_W    = c_DATA_W_DEFAULT,
  parameter int FRAME_LEN = c_FRAME_LEN_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         cont,
  input  logic                         abort,
  input  logic [DATA_W-1:0]            x,
  input  logic                         v,
  output logic                         in_ready,
  output logic [DATA_W-1:0]            peak,
  output logic [$clog2(FRAME_LEN)-1:0] peak_idx,
  output logic                         pk_valid,
  input  logic                         pk_ready,
`ifdef PEAK_NORM_SHIFT_EN
  output logic [4:0]                   norm_shift,
`endif
  output logic                         busy
);

  localparam int c_IDX_W = $clog2(FRAME_LEN);

  peak_state_t         r_state;
  peak_state_t         w_next;
  logic                w_clear;
  logic                w_acc;
  logic                w_last;
  logic                w_new_peak;
  logic [DATA_W-1:0]   w_mag;
  logic [DATA_W-1:0]   r_peak;
  logic [c_IDX_W-1:0]  r_idx;
  logic [c_IDX_W-1:0]  r_cnt;

  // Saturated magnitude of the incoming sample (sign-extended to 64 bits)
  assign w_mag = DATA_W'(sat_mag({{(64 - DATA_W){x[DATA_W-1]}}, x}, DATA_W));

  // A sample is taken only in ACCUM; an abort in the same cycle wins
  assign w_acc      = (r_state == ST_ACCUM) && v && !abort;
  assign w_last     = (r_cnt == c_IDX_W'(FRAME_LEN - 1));
  assign w_new_peak = w_acc && (w_mag > r_peak);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; w_clear marks every path that enters ACCUM or aborts
  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next  = ST_ACCUM;
          w_clear = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (abort) begin
          w_next  = ST_IDLE;
          w_clear = 1'b1;
        end else if (w_acc && w_last) begin
          w_next = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (pk_ready) begin
          if (cont && !abort) begin
            w_next  = ST_ACCUM;
            w_clear = 1'b1;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_next  = ST_IDLE;
        w_clear = 1'b1;
      end
    endcase
  end

  // Running peak, its index and the in-frame sample counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_peak <= '0;
      r_idx  <= '0;
      r_cnt  <= '0;
    end else if (w_clear) begin
      r_peak <= '0;
      r_idx  <= '0;
      r_cnt  <= '0;
    end else if (w_acc) begin
      if (w_new_peak) begin
        r_peak <= w_mag;
        r_idx  <= r_cnt;
      end
      r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef PEAK_NORM_SHIFT_EN
  logic [DATA_W-1:0] w_peak_nxt;
  logic [4:0]        w_shift;
  logic [4:0]        r_norm;

  // Peak value including the sample accepted this cycle
  assign w_peak_nxt = w_new_peak ? w_mag : r_peak;

  norm_shift_calc #(
    .DATA_W (DATA_W)
  ) u_norm_shift_calc (
    .i_val   (w_peak_nxt),
    .o_shift (w_shift)
  );

  // Latch the normalising shift together with the final peak of the frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_norm <= '0;
    end else if (w_acc && w_last) begin
      r_norm <= w_shift;
    end
  end

  assign norm_shift = r_norm;
`endif

  assign in_ready = (r_state == ST_ACCUM);
  assign pk_valid = (r_state == ST_REPORT);
  assign busy     = (r_state != ST_IDLE);
  assign peak     = r_peak;
  assign peak_idx = r_idx;

endmodule

`default_nettype wire

// File: tb/tb_peak_frame_ctrl.sv
// ============================================================================
// Module  : tb_peak_frame_ctrl
// Brief   : Directed self-checking bench for peak_frame_ctrl (FRAME_LEN=8).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_peak_frame_ctrl;

  localparam int c_DW = 16;
  localparam int c_FL = 8;

  typedef struct {
    logic [15:0] pk;
    logic [2:0]  ix;
    logic [4:0]  ns;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        cont;
  logic        abort;
  logic [15:0] x;
  logic        v;
  logic        in_ready;
  logic [15:0] peak;
  logic [2:0]  peak_idx;
  logic        pk_valid;
  logic        pk_ready;
  logic        busy;
`ifdef PEAK_NORM_SHIFT_EN
  logic [4:0]  norm_shift;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t last_e;

  peak_frame_ctrl #(
    .DATA_W    (c_DW),
    .FRAME_LEN (c_FL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cont       (cont),
    .abort      (abort),
    .x          (x),
    .v          (v),
    .in_ready   (in_ready),
    .peak       (peak),
    .peak_idx   (peak_idx),
    .pk_valid   (pk_valid),
    .pk_ready   (pk_ready),
`ifdef PEAK_NORM_SHIFT_EN
    .norm_shift (norm_shift),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] mag(input int s);
    int a;
    a = (s < 0) ? -s : s;
    if (a > 32767) a = 32767;
    return 16'(a);
  endfunction

  function automatic logic [4:0] lead_zeros(input logic [15:0] p);
    int n;
    int b;
    n = 0;
    b = 14;
    while (b >= 0 && p[b] == 1'b0) begin
      n++;
      b--;
    end
    return 5'(n);
  endfunction

  // Reference result of a full frame, pushed to the scoreboard
  task automatic push_expected(input int s[8]);
    exp_t e;
    e.pk = '0;
    e.ix = '0;
    for (int i = 0; i < 8; i++) begin
      if (mag(s[i]) > e.pk) begin
        e.pk = mag(s[i]);
        e.ix = 3'(i);
      end
    end
    e.ns = lead_zeros(e.pk);
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 1);
  endtask

  task automatic drive_frame(input int s[8]);
    push_expected(s);
    for (int i = 0; i < 8; i++) begin
      x = 16'(s[i]);
      v = 1'b1;
      chk("in_ready_accum", {31'd0, in_ready}, 1);
      tick();
    end
    v = 1'b0;
  endtask

  // Wait (bounded) for pk_valid, then pop and compare the frame result
  task automatic expect_report(input int max_wait);
    for (int i = 0; i < max_wait && pk_valid !== 1'b1; i++) begin
      tick();
    end
    chk("pk_valid", {31'd0, pk_valid}, 1);
    if (sb.size() > 0) begin
      last_e = sb.pop_front();
      chk("peak", {16'd0, peak}, {16'd0, last_e.pk});
      chk("peak_idx", {29'd0, peak_idx}, {29'd0, last_e.ix});
`ifdef PEAK_NORM_SHIFT_EN
      chk("norm_shift", {27'd0, norm_shift}, {27'd0, last_e.ns});
`endif
    end else begin
      chk("scoreboard_size", sb.size(), 1);
    end
  endtask

  initial begin
    int fa[8];
    int hits;
    rst = 1'b1; start = 1'b0; cont = 1'b0; abort = 1'b0;
    x = '0; v = 1'b0; pk_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_pk_valid", {31'd0, pk_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_peak", {16'd0, peak}, 0);
    chk("rst_peak_idx", {29'd0, peak_idx}, 0);
`ifdef PEAK_NORM_SHIFT_EN
    chk("rst_norm_shift", {27'd0, norm_shift}, 0);
`endif
    rst = 1'b0;
    tick();

    // Basic frame: latency of one cycle, earliest peak
    do_start();
    fa = '{1, -5, 3, 5, 0, 2, -1, 4};
    drive_frame(fa);
    expect_report(0);
    tick();
    chk("idle_after_single", {31'd0, busy}, 0);
    chk("pk_valid_drop", {31'd0, pk_valid}, 0);

    // Most negative sample saturates; ties keep the earliest index
    do_start();
    fa = '{0, 100, -32768, 32767, -3, 7, -32768, 1};
    drive_frame(fa);
    expect_report(0);
    tick();

    // All-zero frame
    do_start();
    fa = '{0, 0, 0, 0, 0, 0, 0, 0};
    drive_frame(fa);
    expect_report(0);
    tick();

    // Continuous mode with back-pressure; dropped samples while reporting
    cont = 1'b1;
    pk_ready = 1'b0;
    do_start();
    fa = '{-2, 9, -9, 4, -10, 3, 3, 10};
    drive_frame(fa);
    expect_report(0);
    repeat (5) begin
      v = 1'b1;
      x = 16'd30000;
      chk("hold_pk_valid", {31'd0, pk_valid}, 1);
      chk("hold_peak", {16'd0, peak}, {16'd0, last_e.pk});
      chk("hold_peak_idx", {29'd0, peak_idx}, {29'd0, last_e.ix});
      chk("hold_in_ready", {31'd0, in_ready}, 0);
      tick();
    end
    v = 1'b0;
    pk_ready = 1'b1;
    tick();
    chk("cont_in_ready", {31'd0, in_ready}, 1);
    chk("cont_pk_valid_drop", {31'd0, pk_valid}, 0);
    chk("cont_peak_cleared", {16'd0, peak}, 0);
    chk("cont_idx_cleared", {29'd0, peak_idx}, 0);
    fa = '{3, -1, 2, 0, 0, 0, 0, -4};
    drive_frame(fa);
    expect_report(0);
    cont = 1'b0;
    tick();
    chk("idle_after_cont", {31'd0, busy}, 0);

    // Abort after three samples discards the partial frame
    do_start();
    for (int i = 0; i < 3; i++) begin
      x = 16'd30000;
      v = 1'b1;
      tick();
    end
    v = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_in_ready", {31'd0, in_ready}, 0);
    hits = 0;
    repeat (10) begin
      if (pk_valid) hits++;
      tick();
    end
    chk("abort_no_pk_valid", hits, 0);
    do_start();
    fa = '{1, 2, 3, 4, 5, 6, 7, -8};
    drive_frame(fa);
    expect_report(0);
    tick();

    // Handshake together with abort in continuous mode returns to IDLE
    cont = 1'b1;
    pk_ready = 1'b0;
    do_start();
    fa = '{0, 0, 0, 0, 0, 0, -6, 6};
    drive_frame(fa);
    expect_report(0);
    tick();
    chk("bp_still_valid", {31'd0, pk_valid}, 1);
    pk_ready = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    cont = 1'b0;
    chk("abort_hs_busy", {31'd0, busy}, 0);
    chk("abort_hs_in_ready", {31'd0, in_ready}, 0);
    chk("abort_hs_pk_valid", {31'd0, pk_valid}, 0);

    // Asynchronous reset mid-frame
    do_start();
    for (int i = 0; i < 4; i++) begin
      x = 16'd1000;
      v = 1'b1;
      tick();
    end
    v = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_frame_busy", {31'd0, busy}, 0);
    chk("arst_frame_in_ready", {31'd0, in_ready}, 0);
    chk("arst_frame_peak", {16'd0, peak}, 0);
    chk("arst_frame_peak_idx", {29'd0, peak_idx}, 0);
    #1 rst = 1'b0;
    tick();
    hits = 0;
    repeat (12) begin
      if (pk_valid) hits++;
      tick();
    end
    chk("arst_frame_no_pk", hits, 0);

    // Asynchronous reset while a result is pending
    pk_ready = 1'b0;
    do_start();
    fa = '{1, -5, 3, 5, 0, 2, -1, 4};
    drive_frame(fa);
    expect_report(0);
    #2 rst = 1'b1;
    #1;
    chk("arst_rep_pk_valid", {31'd0, pk_valid}, 0);
    chk("arst_rep_busy", {31'd0, busy}, 0);
    chk("arst_rep_peak", {16'd0, peak}, 0);
`ifdef PEAK_NORM_SHIFT_EN
    chk("arst_rep_norm_shift", {27'd0, norm_shift}, 0);
`endif
    #1 rst = 1'b0;
    pk_ready = 1'b1;
    tick();
    hits = 0;
    repeat (12) begin
      if (pk_valid) hits++;
      tick();
    end
    chk("arst_rep_no_pk", hits, 0);

    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
